// File: rtl/matrix_transform_engine_pkg.sv
// Shared matrix-processor package.
// Holds the engine state encoding and the per-element byte stride used to turn
// element indices into byte addresses.
package matrix_transform_engine_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_MAT = 3'd1,
    LOAD_VEC = 3'd2,
    COMPUTE  = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int BYTE_BITS = 8;

  // Byte distance between consecutive elements of a stream of 'width'-bit words.
  function automatic int elem_stride(input int width);
    return width / BYTE_BITS;
  endfunction

endpackage

// File: rtl/matrix_transform_engine_mac_lane.sv
// mac_lane: one multiply-accumulate lane of the transform engine.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears the accumulator)
//   en       : accumulate this cycle
//   clr      : restart the sum with this cycle's product (first column)
//   a, b     : operands; product and sum wrap modulo 2^WIDTH
//   acc      : running sum, held while en is low
module mac_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] product;

  // Truncated to WIDTH bits: two's-complement wrap, no saturation.
  assign product = a * b;
  assign acc     = acc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= (clr ? '0 : acc_reg) + product;
    end
  end

endmodule

// File: rtl/matrix_transform_engine.sv
// matrix_transform_engine: multiplies a cached DIM x DIM matrix by a stream of
// DIM-element vectors fetched from memory and writes each result vector back.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   start, affine                  : job launch (IDLE only); affine mode forces v[DIM-1]=1
//   matrixAddr/dataInAddr/dataOutAddr, workItemCount : job parameters latched at start
//   busy, done                     : busy outside IDLE/DONE, one-cycle done pulse
//   rdValid/rdReady/rdAddr         : read request channel
//   rdRespValid/rdData             : in-order read responses
//   wrValid/wrReady/wrAddr/wrData  : write channel
module matrix_transform_engine
  import matrix_transform_engine_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIM     = 4,
  parameter int WI_BITS = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               affine,
  input  logic [WIDTH-1:0]   matrixAddr,
  input  logic [WIDTH-1:0]   dataInAddr,
  input  logic [WIDTH-1:0]   dataOutAddr,
  input  logic [WI_BITS-1:0] workItemCount,
  output logic               busy,
  output logic               done,
  output logic               rdValid,
  input  logic               rdReady,
  output logic [WIDTH-1:0]   rdAddr,
  input  logic               rdRespValid,
  input  logic [WIDTH-1:0]   rdData,
  output logic               wrValid,
  input  logic               wrReady,
  output logic [WIDTH-1:0]   wrAddr,
  output logic [WIDTH-1:0]   wrData
);

  localparam int CNT_W = $clog2(DIM * DIM + 1);
  localparam int IDX_W = $clog2(DIM * DIM);
  localparam int COL_W = $clog2(DIM);
  localparam logic [WIDTH-1:0] STRIDE     = WIDTH'(elem_stride(WIDTH));
  localparam logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(DIM * elem_stride(WIDTH));
  localparam logic [CNT_W-1:0] MAT_LEN    = CNT_W'(DIM * DIM);

  state_t state_reg, state_next;

  logic               affine_reg;
  logic [WIDTH-1:0]   mat_base_reg, vec_base_reg, out_base_reg;
  logic [WI_BITS-1:0] remaining_reg;
  logic [CNT_W-1:0]   req_cnt_reg, resp_cnt_reg, outstanding_reg;
  logic [COL_W-1:0]   col_cnt_reg, wr_cnt_reg;

  // Operand caches; contents are only meaningful after a load phase.
  logic [WIDTH-1:0] mat_mem [DIM*DIM];
  logic [WIDTH-1:0] vec_mem [DIM];

  logic [WIDTH-1:0] lane_a [DIM];
  logic [WIDTH-1:0] acc    [DIM];
  logic [WIDTH-1:0] vec_elem;

  logic             load_mat, load_vec, loading;
  logic [CNT_W-1:0] phase_len;
  logic             rd_fire, resp_take, phase_done;
  logic             wr_fire, wr_last, col_last;
  logic             compute_en, compute_clr;

  // ---------------- read side ----------------
  assign load_mat  = (state_reg == LOAD_MAT);
  assign load_vec  = (state_reg == LOAD_VEC);
  assign loading   = load_mat || load_vec;
  assign phase_len = load_mat ? MAT_LEN : (affine_reg ? CNT_W'(DIM - 1) : CNT_W'(DIM));

  // Request index only advances on a handshake, so rdAddr holds during stalls.
  assign rdValid   = loading && (req_cnt_reg < phase_len) && (outstanding_reg < MAT_LEN);
  assign rd_fire   = rdValid && rdReady;
  assign rdAddr    = (load_mat ? mat_base_reg : vec_base_reg) + WIDTH'(req_cnt_reg) * STRIDE;

  // Responses outside a load phase (e.g. strays after a reset) are dropped.
  assign resp_take  = rdRespValid && loading && (outstanding_reg != '0);
  assign phase_done = resp_take && (resp_cnt_reg == phase_len - CNT_W'(1));

  // ---------------- compute / write side ----------------
  assign compute_en  = (state_reg == COMPUTE);
  assign compute_clr = (col_cnt_reg == '0);
  assign col_last    = compute_en && (col_cnt_reg == COL_W'(DIM - 1));
  assign vec_elem    = (affine_reg && (col_cnt_reg == COL_W'(DIM - 1))) ? WIDTH'(1)
                                                                      : vec_mem[col_cnt_reg];

  assign wrValid = (state_reg == WRITE);
  assign wr_fire = wrValid && wrReady;
  assign wr_last = wr_fire && (wr_cnt_reg == COL_W'(DIM - 1));
  assign wrAddr  = out_base_reg + WIDTH'(wr_cnt_reg) * STRIDE;
  assign wrData  = acc[wr_cnt_reg];

  // Lane r sees column c of its matrix row each compute cycle.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    assign lane_a[gi] = mat_mem[IDX_W'(gi * DIM) + IDX_W'(col_cnt_reg)];

    mac_lane #(.WIDTH(WIDTH)) u_mac_lane (
      .clk (clk),
      .rst (rst),
      .en  (compute_en),
      .clr (compute_clr),
      .a   (lane_a[gi]),
      .b   (vec_elem),
      .acc (acc[gi])
    );
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (workItemCount == '0) ? DONE : LOAD_MAT;
      end
      LOAD_MAT: begin
        busy = 1'b1;
        if (phase_done) state_next = LOAD_VEC;
      end
      LOAD_VEC: begin
        busy = 1'b1;
        if (phase_done) state_next = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (col_last) state_next = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (wr_last) state_next = (remaining_reg > WI_BITS'(1)) ? LOAD_VEC : DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      affine_reg      <= 1'b0;
      mat_base_reg    <= '0;
      vec_base_reg    <= '0;
      out_base_reg    <= '0;
      remaining_reg   <= '0;
      req_cnt_reg     <= '0;
      resp_cnt_reg    <= '0;
      outstanding_reg <= '0;
      col_cnt_reg     <= '0;
      wr_cnt_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_reg + CNT_W'(rd_fire) - CNT_W'(resp_take);
      case (state_reg)
        IDLE: begin
          if (start) begin
            affine_reg    <= affine;
            mat_base_reg  <= matrixAddr;
            vec_base_reg  <= dataInAddr;
            out_base_reg  <= dataOutAddr;
            remaining_reg <= workItemCount;
            req_cnt_reg   <= '0;
            resp_cnt_reg  <= '0;
            col_cnt_reg   <= '0;
            wr_cnt_reg    <= '0;
          end
        end
        LOAD_MAT, LOAD_VEC: begin
          if (rd_fire)   req_cnt_reg  <= req_cnt_reg + CNT_W'(1);
          if (resp_take) resp_cnt_reg <= resp_cnt_reg + CNT_W'(1);
          // All requests are answered before phase_done, so no rd_fire can collide here.
          if (phase_done) begin
            req_cnt_reg  <= '0;
            resp_cnt_reg <= '0;
          end
        end
        COMPUTE: begin
          col_cnt_reg <= col_last ? '0 : col_cnt_reg + COL_W'(1);
        end
        WRITE: begin
          if (wr_fire) begin
            wr_cnt_reg <= wr_last ? '0 : wr_cnt_reg + COL_W'(1);
            if (wr_last) begin
              if (remaining_reg != '0) remaining_reg <= remaining_reg - WI_BITS'(1);
              vec_base_reg <= vec_base_reg + VEC_STRIDE;
              out_base_reg <= out_base_reg + VEC_STRIDE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Cache fill: responses land in request order at the capture index.
  always_ff @(posedge clk) begin
    if (resp_take) begin
      if (load_mat) mat_mem[IDX_W'(resp_cnt_reg)] <= rdData;
      else          vec_mem[COL_W'(resp_cnt_reg)] <= rdData;
    end
  end

endmodule

// File: tb/tb_matrix_transform_engine.sv
// Directed bench for matrix_transform_engine (DIM=4, WIDTH=32) with a memory
// model that answers reads in order with configurable latency and stalls.
module tb_matrix_transform_engine;

  localparam int WIDTH = 32;
  localparam int DIM   = 4;
  localparam int WI_BITS = 14;
  localparam logic [31:0] MAT_BASE = 32'h0000_0000;
  localparam logic [31:0] IN_BASE  = 32'h0000_0100;
  localparam logic [31:0] OUT_BASE = 32'h0000_0200;

  logic               clk;
  logic               rst, start, affine;
  logic [31:0]        matrixAddr, dataInAddr, dataOutAddr;
  logic [WI_BITS-1:0] workItemCount;
  logic               busy, done;
  logic               rdValid, rdReady, rdRespValid;
  logic [31:0]        rdAddr, rdData;
  logic               wrValid, wrReady;
  logic [31:0]        wrAddr, wrData;

  matrix_transform_engine #(.WIDTH(WIDTH), .DIM(DIM), .WI_BITS(WI_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .affine(affine),
    .matrixAddr(matrixAddr), .dataInAddr(dataInAddr), .dataOutAddr(dataOutAddr),
    .workItemCount(workItemCount), .busy(busy), .done(done),
    .rdValid(rdValid), .rdReady(rdReady), .rdAddr(rdAddr),
    .rdRespValid(rdRespValid), .rdData(rdData),
    .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- memory model / monitor ----------------
  typedef struct { logic [31:0] data; int due; } resp_t;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_rd_q [$];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  resp_t       resp_q [$];
  int cyc = 0, rd_cnt = 0, done_cnt = 0, rdv_seen = 0, wrv_seen = 0;
  int rd_limit = 1000000, fixed_lat = 1;
  bit rand_mode = 0;
  bit rd_stall_prev = 0, wr_stall_prev = 0;
  logic [31:0] prev_rd_addr, prev_wr_addr, prev_wr_data;

  initial begin
    rdReady = 1'b1; wrReady = 1'b1; rdRespValid = 1'b0; rdData = '0;
    forever begin
      resp_t r;
      logic [31:0] ea;
      @(negedge clk);
      cyc++;
      // Ready values for the coming edge are chosen first, then the handshake
      // is evaluated with them (DUT valids only change on posedge).
      rdReady = (rd_cnt < rd_limit) && (!rand_mode || $urandom_range(0, 2) != 0);
      wrReady = !rand_mode || $urandom_range(0, 2) != 0;
      if (done === 1'b1) done_cnt++;
      // Response for the coming edge.
      if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
        rdRespValid = 1'b1; rdData = resp_q[0].data; void'(resp_q.pop_front());
      end else begin
        rdRespValid = 1'b0; rdData = 32'hDEAD_BEEF;
      end
      if (rdValid === 1'b1) begin
        rdv_seen++;
        if (rd_stall_prev) begin
          vectors++;
          if (rdAddr !== prev_rd_addr) begin
            miscompares++;
            $display("FAIL rd_addr_stable: got %h, required %h", rdAddr, prev_rd_addr);
          end
        end
        if (rdReady) begin
          rd_cnt++;
          vectors++;
          ea = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : 32'hFFFF_FFFF;
          if (rdAddr !== ea) begin
            miscompares++;
            $display("FAIL rd_addr_seq: got %h, required %h", rdAddr, ea);
          end
          r.data = mem[rdAddr[11:2]];
          r.due  = cyc + (rand_mode ? int'($urandom_range(1, 5)) : fixed_lat);
          resp_q.push_back(r);
          $display("rd  addr=%h data=%h", rdAddr, r.data);
          rd_stall_prev = 0;
        end else begin
          rd_stall_prev = 1; prev_rd_addr = rdAddr;
        end
      end else begin
        rd_stall_prev = 0;
      end
      if (wrValid === 1'b1) begin
        wrv_seen++;
        if (wr_stall_prev) begin
          vectors++;
          if (wrAddr !== prev_wr_addr || wrData !== prev_wr_data) begin
            miscompares++;
            $display("FAIL wr_stable: got %h/%h, required %h/%h", wrAddr, wrData, prev_wr_addr, prev_wr_data);
          end
        end
        if (wrReady) begin
          wr_addr_q.push_back(wrAddr); wr_data_q.push_back(wrData);
          $display("wr  addr=%h data=%h", wrAddr, wrData);
          wr_stall_prev = 0;
        end else begin
          wr_stall_prev = 1; prev_wr_addr = wrAddr; prev_wr_data = wrData;
        end
      end else begin
        wr_stall_prev = 0;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic load_identity();
    for (int r = 0; r < 4; r++) mem[r*4 + r] = 32'd1;
  endtask

  task automatic expect_reads(input bit aff, input int cnt);
    exp_rd_q.delete();
    for (int k = 0; k < 16; k++) exp_rd_q.push_back(MAT_BASE + 32'(4*k));
    for (int i = 0; i < cnt; i++)
      for (int k = 0; k < (aff ? 3 : 4); k++) exp_rd_q.push_back(IN_BASE + 32'(16*i + 4*k));
  endtask

  task automatic launch(input logic aff, input logic [WI_BITS-1:0] cnt);
    @(posedge clk); #1;
    wr_addr_q.delete(); wr_data_q.delete();
    rd_cnt = 0; done_cnt = 0; rdv_seen = 0; wrv_seen = 0;
    matrixAddr = MAT_BASE; dataInAddr = IN_BASE; dataOutAddr = OUT_BASE;
    affine = aff; workItemCount = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; affine = 1'b0;
  endtask

  task automatic run_job(input logic aff, input logic [WI_BITS-1:0] cnt, input int budget,
                         output bit ok);
    launch(aff, cnt);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done_cnt != 0) ok = 1;
      else begin @(posedge clk); #1; end
    end
    repeat (3) @(posedge clk);
    #1;
    $display("job affine=%0d count=%0d finished=%0d", aff, cnt, ok);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; affine = 1'b0; workItemCount = '0;
    matrixAddr = '0; dataInAddr = '0; dataOutAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL reset_done: got %b, required 0", done); end
    vectors++; if (rdValid !== 1'b0) begin miscompares++; $display("FAIL reset_rdvalid: got %b, required 0", rdValid); end
    vectors++; if (wrValid !== 1'b0) begin miscompares++; $display("FAIL reset_wrvalid: got %b, required 0", wrValid); end
    rst = 1'b0;
  endtask

  task automatic test_zero_count();
    exp_rd_q.delete();
    launch(1'b0, '0);
    // Start was sampled on the previous edge: DONE is the current state.
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b, required 1", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width: got %b, required 0", done); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (rdv_seen != 0 || wrv_seen != 0) begin
      miscompares++; $display("FAIL zero_traffic: got rd=%0d wr=%0d, required 0/0", rdv_seen, wrv_seen);
    end
  endtask

  task automatic test_identity();
    bit ok;
    clear_mem(); load_identity();
    for (int i = 0; i < 8; i++) mem[64 + i] = 32'(i + 1);
    expect_reads(0, 2);
    run_job(1'b0, 14'd2, 500, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL identity_timeout: got no done, required done"); end
    vectors++; if (wr_data_q.size() != 8) begin miscompares++; $display("FAIL identity_wr_count: got %0d, required 8", wr_data_q.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (wr_addr_q.size() <= i || wr_addr_q[i] !== OUT_BASE + 32'(4*i) || wr_data_q[i] !== 32'(i + 1)) begin
        miscompares++; $display("FAIL identity_out[%0d]: got %h@%h, required %h@%h", i,
          (wr_data_q.size() > i) ? wr_data_q[i] : 32'hX, (wr_addr_q.size() > i) ? wr_addr_q[i] : 32'hX,
          32'(i + 1), OUT_BASE + 32'(4*i));
      end
    end
    vectors++; if (rd_cnt != 24)  begin miscompares++; $display("FAIL identity_rd_count: got %0d, required 24", rd_cnt); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL identity_done_pulses: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_affine();
    bit ok;
    logic [31:0] exp_out [4];
    exp_out = '{32'd11, 32'd22, 32'd33, 32'd1};
    clear_mem(); load_identity();
    mem[3] = 32'd10; mem[7] = 32'd20; mem[11] = 32'd30;
    mem[64] = 32'd1; mem[65] = 32'd2; mem[66] = 32'd3; mem[67] = 32'd99;
    expect_reads(1, 1);
    run_job(1'b1, 14'd1, 500, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL affine_timeout: got no done, required done"); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_data_q.size() <= i || wr_addr_q[i] !== OUT_BASE + 32'(4*i) || wr_data_q[i] !== exp_out[i]) begin
        miscompares++; $display("FAIL affine_out[%0d]: got %h, required %h", i,
          (wr_data_q.size() > i) ? wr_data_q[i] : 32'hX, exp_out[i]);
      end
    end
    vectors++; if (rd_cnt != 19) begin miscompares++; $display("FAIL affine_rd_count: got %0d, required 19", rd_cnt); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_out [4];
    exp_out = '{32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0};
    clear_mem();
    mem[0] = 32'hFFFF_FFFF; mem[64] = 32'd2;
    expect_reads(0, 1);
    run_job(1'b0, 14'd1, 500, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got no done, required done"); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_data_q.size() <= i || wr_data_q[i] !== exp_out[i]) begin
        miscompares++; $display("FAIL wrap_out[%0d]: got %h, required %h", i,
          (wr_data_q.size() > i) ? wr_data_q[i] : 32'hX, exp_out[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp_out [8];
    // M[r][c] = 4r+c+1; v0=(1,2,3,4), v1=(5,6,7,8)
    exp_out = '{32'd30, 32'd70, 32'd110, 32'd150, 32'd70, 32'd174, 32'd278, 32'd382};
    clear_mem();
    for (int k = 0; k < 16; k++) mem[k] = 32'(k + 1);
    for (int i = 0; i < 8; i++) mem[64 + i] = 32'(i + 1);
    expect_reads(0, 2);
    rand_mode = 1;
    run_job(1'b0, 14'd2, 3000, ok);
    rand_mode = 0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: got no done, required done"); end
    vectors++; if (wr_data_q.size() != 8) begin miscompares++; $display("FAIL bp_wr_count: got %0d, required 8", wr_data_q.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (wr_data_q.size() <= i || wr_addr_q[i] !== OUT_BASE + 32'(4*i) || wr_data_q[i] !== exp_out[i]) begin
        miscompares++; $display("FAIL bp_out[%0d]: got %h, required %h", i,
          (wr_data_q.size() > i) ? wr_data_q[i] : 32'hX, exp_out[i]);
      end
    end
    vectors++; if (rd_cnt != 24) begin miscompares++; $display("FAIL bp_rd_count: got %0d, required 24", rd_cnt); end
  endtask

  task automatic test_reset_mid_load_vec();
    bit ok;
    clear_mem(); load_identity();
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'(i + 1);
    expect_reads(0, 1);
    fixed_lat = 20; rd_limit = 19;   // 16 matrix + 3 vector reads, then stall
    launch(1'b0, 14'd1);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (rd_cnt == 19) ok = 1;
      else begin @(posedge clk); #1; end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_reach: got %0d reads, required 19", rd_cnt); end
    vectors++; if (resp_q.size() != 3) begin miscompares++; $display("FAIL rstmid_outstanding: got %0d, required 3", resp_q.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    vectors++; if (rdValid !== 1'b0) begin miscompares++; $display("FAIL rstmid_rdvalid: got %b, required 0", rdValid); end
    rd_limit = 1000000; fixed_lat = 1;
    repeat (30) @(posedge clk);   // stray responses drain while idle
    #1;
    vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL rstmid_done: got %0d pulses, required 0", done_cnt); end
    // Follow-up job must be unaffected by the strays.
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'(i + 21);
    expect_reads(0, 1);
    run_job(1'b0, 14'd1, 500, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_next_timeout: got no done, required done"); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_data_q.size() <= i || wr_data_q[i] !== 32'(i + 21)) begin
        miscompares++; $display("FAIL rstmid_next_out[%0d]: got %h, required %h", i,
          (wr_data_q.size() > i) ? wr_data_q[i] : 32'hX, 32'(i + 21));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_identity();
    test_affine();
    test_wrap();
    test_backpressure();
    test_reset_mid_load_vec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
